// File: rtl/sync_gen.sv
// Periodic sync-pulse generator: armed by software, started by a trig rising edge, free-runs at a latched period.
// Latency: first sync one cycle after the sampled edge (three cycles from the pin with SYNC_GEN_TRIG_SYNC_EN).
// Backpressure: none; sync/dout/data_valid are one-cycle strobes that the consumer must take as they come.
module sync_gen #(
  parameter int DATA_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    trig,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    sync,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    data_valid,
  output logic                    running,
  output logic                    armed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_trig_q;
  logic                    w_trig_s;
  logic                    w_edge;
  logic [PERIOD_WIDTH-1:0] w_period_clamp;

`ifdef SYNC_GEN_TRIG_SYNC_EN
  logic r_trig_meta;
  logic r_trig_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig_meta <= 1'b0;
      r_trig_sync <= 1'b0;
    end else begin
      r_trig_meta <= trig;
      r_trig_sync <= r_trig_meta;
    end
  end

  assign w_trig_s = r_trig_sync;
`else
  assign w_trig_s = trig;
`endif

  assign w_edge         = w_trig_s & ~r_trig_q;
  // A period below 2 would let sync stay high on back-to-back cycles.
  assign w_period_clamp = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : period;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_period   <= '0;
      r_cnt      <= '0;
      r_trig_q   <= 1'b0;
      sync       <= 1'b0;
      data_valid <= 1'b0;
      dout       <= '0;
      running    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      r_trig_q   <= w_trig_s;
      sync       <= 1'b0;
      data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (arm && !stop) begin
            r_period <= w_period_clamp;
            r_state  <= ST_ARMED;
            armed    <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            r_state <= ST_IDLE;
            armed   <= 1'b0;
          end else if (w_edge) begin
            // The first pulse is emitted on entry; the counter then times the rest.
            r_state    <= ST_RUN;
            armed      <= 1'b0;
            running    <= 1'b1;
            r_cnt      <= r_period - PERIOD_WIDTH'(1);
            sync       <= 1'b1;
            data_valid <= 1'b1;
            dout       <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            running <= 1'b0;
          end else if (r_cnt == '0) begin
            r_cnt      <= r_period - PERIOD_WIDTH'(1);
            sync       <= 1'b1;
            data_valid <= 1'b1;
            dout       <= dout + DATA_WIDTH'(1);
          end else begin
            r_cnt <= r_cnt - PERIOD_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          running <= 1'b0;
          armed   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_gen.sv
// Directed bench for sync_gen: a 32-bit and a 4-bit instance share stimulus; expectations are hand-derived.
module tb_sync_gen;

`ifdef SYNC_GEN_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        arm;
  logic        stop;
  logic        trig;
  logic [15:0] period;
  logic        sync, data_valid, running, armed;
  logic [31:0] dout;
  logic        sync4, data_valid4, running4, armed4;
  logic [3:0]  dout4;

  int tests = 0;
  int fails = 0;

  sync_gen #(.DATA_WIDTH(32), .PERIOD_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig(trig), .period(period),
    .sync(sync), .dout(dout), .data_valid(data_valid), .running(running), .armed(armed)
  );

  sync_gen #(.DATA_WIDTH(4), .PERIOD_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig(trig), .period(period),
    .sync(sync4), .dout(dout4), .data_valid(data_valid4), .running(running4), .armed(armed4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; arm = 1'b1; stop = 1'b0; trig = 1'b0; period = 16'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({sync, data_valid, running, armed, dout} !== 36'd0) begin
        fails++;
        $display("FAIL reset_outs cyc=%0d got s=%b v=%b r=%b a=%b d=%0h want all 0", i, sync, data_valid, running, armed, dout);
      end
      tests++;
      if ({sync4, data_valid4, running4, armed4, dout4} !== 8'd0) begin
        fails++;
        $display("FAIL reset_outs4 cyc=%0d got dout4=%0h armed4=%b want 0", i, dout4, armed4);
      end
    end
    arm = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic arm_dut(input int p);
    period = 16'(p);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tests++;
    if ({armed, running, sync} !== 3'b100) begin
      fails++;
      $display("FAIL arm p=%0d got armed=%b running=%b sync=%b want 1 0 0", p, armed, running, sync);
    end
  endtask

  // Raises trig in the current cycle, then checks n following cycles.
  task automatic run_check(input int p, input int n, input bit retrig);
    int pe;
    bit exp_s;
    pe = (p < 2) ? 2 : p;
    trig = 1'b1;
    period = 16'hffff;
    for (int j = 1; j <= n; j++) begin
      tick();
      exp_s = (j >= LAT) && (((j - LAT) % pe) == 0);
      tests++;
      if (sync !== exp_s || data_valid !== exp_s) begin
        fails++;
        $display("FAIL run_sync p=%0d j=%0d got sync=%b dv=%b want %b", p, j, sync, data_valid, exp_s);
      end
      tests++;
      if (running !== (j >= LAT) || armed !== (j < LAT)) begin
        fails++;
        $display("FAIL run_state p=%0d j=%0d got running=%b armed=%b want %b %b", p, j, running, armed, j >= LAT, j < LAT);
      end
      if (j >= LAT) begin
        tests++;
        if (dout !== 32'((j - LAT) / pe) || dout4 !== 4'(((j - LAT) / pe) % 16)) begin
          fails++;
          $display("FAIL run_dout p=%0d j=%0d got dout=%0d dout4=%0d want %0d %0d", p, j, dout, dout4, (j - LAT) / pe, ((j - LAT) / pe) % 16);
        end
      end
      if (retrig && j > LAT) trig = j[0];
    end
  endtask

  task automatic stop_check(input int exp_d);
    stop = 1'b1;
    trig = 1'b0;
    tick();
    stop = 1'b0;
    tests++;
    if ({sync, running, armed} !== 3'b000 || dout !== 32'(exp_d) || dout4 !== 4'(exp_d % 16)) begin
      fails++;
      $display("FAIL stop_now got s=%b r=%b a=%b dout=%0d dout4=%0d want 0 0 0 %0d %0d", sync, running, armed, dout, dout4, exp_d, exp_d % 16);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if ({sync, data_valid, running} !== 3'b000 || dout !== 32'(exp_d)) begin
        fails++;
        $display("FAIL stop_hold i=%0d got s=%b v=%b r=%b dout=%0d want 0 0 0 %0d", i, sync, data_valid, running, dout, exp_d);
      end
    end
  endtask

  task automatic test_basic();
    arm_dut(5);
    run_check(5, LAT + 14, 1'b0);
    stop_check(2);
  endtask

  task automatic test_clamp();
    arm_dut(0);
    run_check(0, LAT + 5, 1'b0);
    stop_check(2);
    arm_dut(1);
    run_check(1, LAT + 4, 1'b0);
    stop_check(2);
  endtask

  task automatic test_retrig();
    arm_dut(3);
    run_check(3, LAT + 12, 1'b1);
    stop_check(4);
  endtask

  task automatic test_wrap();
    arm_dut(2);
    run_check(2, LAT + 34, 1'b0);
    stop_check(17);
  endtask

  task automatic test_idle_ignores();
    for (int i = 0; i < 8; i++) begin
      trig = i[0];
      tick();
      tests++;
      if ({sync, running, armed} !== 3'b000) begin
        fails++;
        $display("FAIL idle_trig i=%0d got s=%b r=%b a=%b want 0 0 0", i, sync, running, armed);
      end
    end
    trig = 1'b0;
    arm = 1'b1;
    stop = 1'b1;
    tick();
    arm = 1'b0;
    stop = 1'b0;
    tests++;
    if (armed !== 1'b0) begin
      fails++;
      $display("FAIL arm_stop_idle got armed=%b want 0", armed);
    end
    arm_dut(4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if (armed !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL stop_armed got armed=%b running=%b want 0 0", armed, running);
    end
    trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({sync, running} !== 2'b00) begin
        fails++;
        $display("FAIL trig_after_stop i=%0d got s=%b r=%b want 0 0", i, sync, running);
      end
    end
    trig = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    arm_dut(3);
    run_check(3, LAT + 4, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if ({sync, data_valid, running, armed, dout} !== 36'd0 || dout4 !== 4'd0) begin
      fails++;
      $display("FAIL async_rst got s=%b v=%b r=%b a=%b dout=%0d want all 0", sync, data_valid, running, armed, dout);
    end
    trig = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if ({sync, running, armed} !== 3'b000) begin
        fails++;
        $display("FAIL post_rst_trig i=%0d got s=%b r=%b a=%b want 0 0 0", i, sync, running, armed);
      end
    end
    trig = 1'b0;
    repeat (4) tick();
    arm_dut(4);
    run_check(4, LAT + 9, 1'b0);
    stop_check(2);
  endtask

  initial begin
    test_reset();
    repeat (8) tick();
    test_basic();
    test_clamp();
    test_retrig();
    test_wrap();
    test_idle_ignores();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_gen.md
# sync_gen

Programmable periodic sync-pulse generator that sits directly upstream of `sync_delay`. It produces a one-cycle `sync` strobe and a running pulse index on `dout`/`data_valid`, which feeds the delay stage's `din`. It is armed by software, started by an external trigger edge, and free-runs at a latched period until stopped.

## Interface
- `DATA_WIDTH`, 32: width of the `dout` pulse index; matches the `sync_delay` `din` width.
- `PERIOD_WIDTH`, 16: width of the `period` input and the internal period counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `arm`  in  1  level; while in IDLE, a 1 latches `period` and moves to ARMED.
- `stop`  in  1  level; a 1 returns the block to IDLE from any state.
- `trig`  in  1  external trigger; only its rising edge is used.
- `period`  in  PERIOD_WIDTH  sync spacing in cycles; sampled only on arm.
- `sync`  out  1  one-cycle sync strobe.
- `dout`  out  DATA_WIDTH  index of the current pulse; 0 for the first pulse after a trigger.
- `data_valid`  out  1  high on the cycle `dout` is updated (same cycle as `sync`).
- `running`  out  1  high in RUN.
- `armed`  out  1  high in ARMED.

## Operation
- Reset (`rst`=0, asynchronous) forces the following; all outputs are registered:
  - state = IDLE
  - `sync`=0, `data_valid`=0, `dout`=0, `running`=0, `armed`=0
  - period counter = 0, trigger edge-detect history = 0
- States:
  - **IDLE**: `arm`=1 and `stop`=0 → ARMED. On that transition, latch P = max(`period`, 2).
  - **ARMED**: `stop`=1 → IDLE. A trigger rising edge → RUN, and the period counter loads P-1.
  - **RUN**: `stop`=1 → IDLE. Otherwise the counter decrements each cycle; at 0 it reloads P-1 and emits a pulse.
- Trigger edge detect:
  - `trig_q` is the registered `trig`; an edge is `trig & ~trig_q`.
  - Edges seen in IDLE or RUN are ignored. Retriggering while running does not restart the phase.
- Pulse emission:
  - Each pulse drives `sync`=1 and `data_valid`=1 for exactly one cycle.
  - The first pulse after entering RUN carries `dout`=0. Each later pulse carries the previous `dout`+1, modulo 2^DATA_WIDTH, so it wraps from all-ones to 0 with no flag.
- `dout` holds its last value between pulses and while in IDLE. It clears to 0 only on reset or on the ARMED→RUN transition.
- Simultaneous events:
  - `stop` has priority over `arm` and trigger.
  - If `stop` and the terminal count land on the same cycle, no pulse is emitted.
- `period` changes after arming have no effect until the next IDLE→ARMED transition.

## Timing
- Let the edge be sampled at cycle N (`trig`=0 at N-1, 1 at N).
  - First `sync`/`data_valid` is high in cycle N+1.
  - Subsequent pulses are at N+1+k·P.
- `armed` rises the cycle after `arm` is sampled in IDLE.
- `running` rises with the first `sync`.
- `stop` sampled at cycle M: `running`/`armed` are 0 from M+1, and no `sync` occurs at M+1 or later.
- Minimum spacing: with P=2, `sync` toggles 1,0,1,0. `sync` is never high on two consecutive cycles.
- Asynchronous reset mid-RUN clears outputs immediately. The pulse in flight is dropped.

## Configuration
- `SYNC_GEN_TRIG_SYNC_EN` defined:
  - `trig` passes through a two-flop synchronizer before edge detect, for asynchronous trigger sources.
  - The first pulse moves to cycle N+3, where N is the cycle `trig` first reads 1 at the pin.
  - Both synchronizer flops reset to 0.
- Not defined: `trig` is assumed synchronous to `clk`, and the first pulse is at N+1.

## Test plan
- Reset release, `arm` with `period`=5, trigger rise at cycle 10 → `sync` at 11, 16, 21; `dout` = 0, 1, 2 at those cycles; `data_valid` coincident with `sync`.
- `period`=0 and `period`=1 → both clamp to P=2; `sync` at N+1, N+3, N+5.
- In RUN, assert `stop` one cycle before a terminal count → no further `sync`; `running`=0 next cycle; `dout` holds its last value.
- `DATA_WIDTH`=4, run 17 pulses → `dout` sequence 0..15 then 0.
- Trigger edges in IDLE and during RUN → ignored: no state change and no pulse-phase shift. `arm` and `stop` asserted together in IDLE → stays IDLE.
- With `SYNC_GEN_TRIG_SYNC_EN`: trigger rise at cycle 10 → first `sync` at 13. Assert `rst`=0 mid-RUN → all outputs are 0 immediately and the block restarts only after a new arm and trigger.
